cnn_layer_controller: RTL

- Sequencer on the controller side of the 4-bit sig_in/sig_out handshake used by the binary-convolution datapath.
- Drives the one-hot command word (get_address, get_data, count_ready, write_ready) and waits for the matching acknowledge.
- Steps through NUM_WINDOWS convolution windows, issuing one SRAM result write per window.
- Sits between the top-level start/done interface and the datapath/SRAM.

---
 rtl/cnn_pkg.sv | 34 +++
 rtl/cnn_wait_timer.sv | 27 ++
 rtl/cnn_layer_controller.sv | 187 ++++++++++++++++++
 3 files changed

// File: rtl/cnn_pkg.sv
// Shared definitions for the binary-convolution layer controller: state
// encoding, one-hot command words and ack bit positions on sig_in/sig_out.
package cnn_pkg;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_ADDR  = 3'd1,
      ST_LAT   = 3'd2,
      ST_DATA  = 3'd3,
      ST_COUNT = 3'd4,
      ST_WRITE = 3'd5,
      ST_GAP   = 3'd6,
      ST_FIN   = 3'd7
   } cnn_state_e;

   localparam logic [3:0] CMD_GET_ADDR = 4'b1000;
   localparam logic [3:0] CMD_GET_DATA = 4'b0100;
   localparam logic [3:0] CMD_COUNT    = 4'b0010;
   localparam logic [3:0] CMD_WRITE    = 4'b0001;
   localparam logic [3:0] CMD_NONE     = 4'b0000;

   localparam int ACK_GOT_DATA   = 3;
   localparam int ACK_READY      = 2;
   localparam int ACK_COUNT_DONE = 1;
   localparam int ACK_WRITTEN    = 0;

   localparam int TMR_W = 16;

   // States in which the controller holds a command and waits for its ack.
   function automatic logic is_wait_state(input cnn_state_e s);
      return (s == ST_ADDR) || (s == ST_DATA) || (s == ST_COUNT) || (s == ST_WRITE);
   endfunction

endpackage

// File: rtl/cnn_wait_timer.sv
// Loadable down-counter; load wins over decrement and the count parks at zero.
module cnn_wait_timer #(
   parameter int W = 16
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         load_i,
   input  logic [W-1:0] load_val_i,
   input  logic         dec_i,
   output logic         zero_o
);

   logic [W-1:0] count_q;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         count_q <= '0;
      end else if (load_i) begin
         count_q <= load_val_i;
      end else if (dec_i && (count_q != '0)) begin
         count_q <= count_q - 1'b1;
      end
   end

   assign zero_o = (count_q == '0);

endmodule

// File: rtl/cnn_layer_controller.sv
// Layer sequencer driving the one-hot sig_in command / sig_out ack handshake,
// one SRAM result write per window. Ack-wait timeout enabled by CNN_CTRL_TIMEOUT_EN.
module cnn_layer_controller
   import cnn_pkg::*;
#(
   parameter int NUM_WINDOWS = 16,
   parameter int ADDR_W      = 12,
   parameter int RD_LAT      = 1,
   parameter int TIMEOUT     = 255
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic [3:0]        sig_out,
   output logic [3:0]        sig_in,
   output logic [ADDR_W-1:0] read_base,
   output logic              write_en,
   output logic [ADDR_W-1:0] write_addr,
   output logic              busy,
   output logic              done,
   output logic              timeout_err,
   output cnn_state_e        dbg_state
);

   localparam logic [ADDR_W-1:0] LAST_WIN = ADDR_W'(NUM_WINDOWS - 1);
   localparam logic [TMR_W-1:0]  LAT_LOAD = TMR_W'(RD_LAT);
   localparam logic [TMR_W-1:0]  TMO_LOAD = TMR_W'(TIMEOUT - 1);

   cnn_state_e        state_q;
   logic [3:0]        cmd_q;
   logic [ADDR_W-1:0] window_q;
   logic [ADDR_W-1:0] read_base_q;
   logic [ADDR_W-1:0] wr_addr_q;
   logic              wr_en_q;
   logic              busy_q;
   logic              done_q;
   logic              tmo_err_q;

   logic              tmr_load_d;
   logic [TMR_W-1:0]  tmr_val_d;
   logic              tmr_dec_d;
   logic              tmr_zero;
   logic              tmo_hit;

   // The timer holds the read latency in LAT; with the timeout enabled it is
   // reloaded on entry to every ack-wait state and runs down while waiting.
   always_comb begin
      tmr_load_d = 1'b0;
      tmr_val_d  = TMO_LOAD;
      tmr_dec_d  = (state_q == ST_LAT);
      if (state_q == ST_ADDR && sig_out[ACK_READY]) begin
         tmr_load_d = 1'b1;
         tmr_val_d  = LAT_LOAD;
      end
`ifdef CNN_CTRL_TIMEOUT_EN
      if (is_wait_state(state_q)) tmr_dec_d = 1'b1;
      if ((state_q == ST_IDLE  && start && !done_q) ||
          (state_q == ST_LAT   && tmr_zero) ||
          (state_q == ST_DATA  && sig_out[ACK_GOT_DATA]) ||
          (state_q == ST_COUNT && sig_out[ACK_COUNT_DONE]) ||
          (state_q == ST_GAP)) begin
         tmr_load_d = 1'b1;
      end
`endif
   end

`ifdef CNN_CTRL_TIMEOUT_EN
   assign tmo_hit = is_wait_state(state_q) && tmr_zero;
`else
   assign tmo_hit = 1'b0;
`endif

   cnn_wait_timer #(.W(TMR_W)) u_timer (
      .clk        (clk),
      .reset      (reset),
      .load_i     (tmr_load_d),
      .load_val_i (tmr_val_d),
      .dec_i      (tmr_dec_d),
      .zero_o     (tmr_zero)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q     <= ST_IDLE;
         cmd_q       <= CMD_NONE;
         window_q    <= '0;
         read_base_q <= '0;
         wr_addr_q   <= '0;
         wr_en_q     <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         tmo_err_q   <= 1'b0;
      end else begin
         wr_en_q <= 1'b0;
         done_q  <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               // A start landing on the done cycle is dropped, not queued.
               if (start && !done_q) begin
                  state_q     <= ST_ADDR;
                  cmd_q       <= CMD_GET_ADDR;
                  busy_q      <= 1'b1;
                  window_q    <= '0;
                  read_base_q <= '0;
               end
            end
            ST_ADDR: begin
               if (sig_out[ACK_READY]) begin
                  state_q <= ST_LAT;
                  cmd_q   <= CMD_NONE;
               end else if (tmo_hit) begin
                  state_q   <= ST_FIN;
                  cmd_q     <= CMD_NONE;
                  tmo_err_q <= 1'b1;
               end
            end
            ST_LAT: begin
               if (tmr_zero) begin
                  state_q <= ST_DATA;
                  cmd_q   <= CMD_GET_DATA;
               end
            end
            ST_DATA: begin
               if (sig_out[ACK_GOT_DATA]) begin
                  state_q <= ST_COUNT;
                  cmd_q   <= CMD_COUNT;
               end else if (tmo_hit) begin
                  state_q   <= ST_FIN;
                  cmd_q     <= CMD_NONE;
                  tmo_err_q <= 1'b1;
               end
            end
            ST_COUNT: begin
               if (sig_out[ACK_COUNT_DONE]) begin
                  state_q <= ST_WRITE;
                  cmd_q   <= CMD_WRITE;
               end else if (tmo_hit) begin
                  state_q   <= ST_FIN;
                  cmd_q     <= CMD_NONE;
                  tmo_err_q <= 1'b1;
               end
            end
            ST_WRITE: begin
               if (sig_out[ACK_WRITTEN]) begin
                  wr_en_q   <= 1'b1;
                  wr_addr_q <= window_q;
                  cmd_q     <= CMD_NONE;
                  if (window_q == LAST_WIN) begin
                     state_q <= ST_FIN;
                  end else begin
                     state_q     <= ST_GAP;
                     window_q    <= window_q + 1'b1;
                     read_base_q <= window_q + 1'b1;
                  end
               end else if (tmo_hit) begin
                  state_q   <= ST_FIN;
                  cmd_q     <= CMD_NONE;
                  tmo_err_q <= 1'b1;
               end
            end
            ST_GAP: begin
               state_q <= ST_ADDR;
               cmd_q   <= CMD_GET_ADDR;
            end
            ST_FIN: begin
               state_q <= ST_IDLE;
               done_q  <= 1'b1;
               busy_q  <= 1'b0;
            end
            default: begin
               state_q <= ST_IDLE;
               cmd_q   <= CMD_NONE;
            end
         endcase
      end
   end

   assign sig_in      = cmd_q;
   assign read_base   = read_base_q;
   assign write_en    = wr_en_q;
   assign write_addr  = wr_addr_q;
   assign busy        = busy_q;
   assign done        = done_q;
   assign timeout_err = tmo_err_q;
   assign dbg_state   = state_q;

endmodule
